// File: rtl/midi_parser.sv
// MIDI byte-stream parser: running status, real-time filtering, Note On/Off and CC decode,
// plus an all-notes-off strobe driven by CC 120/123 or an Active Sensing timeout.
`ifndef MIDI_PAYLOAD_BITS
`define MIDI_PAYLOAD_BITS 7
`endif

module midi_parser #(
  parameter int MIDI_CHANNEL  = 0,
  parameter int OMNI          = 0,
  parameter int VEL0_IS_OFF   = 1,
  parameter int SENSE_TIMEOUT = 300000
) (
  input  logic                          clk_i,
  input  logic                          nrst_i,
  input  logic                          midiByteValid_i,
  input  logic [7:0]                    midiByte_i,
  output logic [`MIDI_PAYLOAD_BITS-1:0] note_o,
  output logic [`MIDI_PAYLOAD_BITS-1:0] velocity_o,
  output logic [3:0]                    channel_o,
  output logic                          noteOnStrb_o,
  output logic                          noteOffStrb_o,
  output logic                          ccStrb_o,
  output logic                          allOffStrb_o
);

  localparam int PW = `MIDI_PAYLOAD_BITS;
  localparam int TW = (SENSE_TIMEOUT < 2) ? 1 : $clog2(SENSE_TIMEOUT);
  localparam logic [3:0] CH = MIDI_CHANNEL[3:0];
  localparam logic [TW-1:0] LOAD = TW'(SENSE_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, DATA1, DATA2, SKIP} state_t;

  state_t        state, state_next;
  logic [3:0]    cmd, chan;
  logic          accept;
  logic [6:0]    d1;
  logic          armed;
  logic [TW-1:0] cnt;

  logic is_rt, is_sys, is_voice, is_data, sys_reset, complete, timer_fire;
  logic on_next, off_next, cc_next, ao_cc;
  logic [PW-1:0] note_next, vel_next;
  logic [3:0]    chan_next;

  // Data bytes carry 7 bits; widen or narrow them to the payload width.
  function automatic logic [PW-1:0] to_payload(input logic [6:0] v);
    logic [PW+6:0] tmp;
    tmp = {{PW{1'b0}}, v};
    return tmp[PW-1:0];
  endfunction

  assign is_rt      = midiByteValid_i && (midiByte_i[7:3] == 5'b11111);
  assign is_sys     = midiByteValid_i && (midiByte_i[7:3] == 5'b11110);
  assign is_voice   = midiByteValid_i && midiByte_i[7] && (midiByte_i[7:4] != 4'hF);
  assign is_data    = midiByteValid_i && !midiByte_i[7];
  assign sys_reset  = is_rt && (midiByte_i == 8'hFF);
  assign complete   = is_data && ((state == DATA2) ||
                      ((state == DATA1) && ((cmd == 4'hC) || (cmd == 4'hD))));
  assign timer_fire = armed && !midiByteValid_i && (cnt == '0);

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state         <= IDLE;
      cmd           <= '0;
      chan          <= '0;
      accept        <= 1'b0;
      d1            <= '0;
      armed         <= 1'b0;
      cnt           <= '0;
      note_o        <= '0;
      velocity_o    <= '0;
      channel_o     <= '0;
      noteOnStrb_o  <= 1'b0;
      noteOffStrb_o <= 1'b0;
      ccStrb_o      <= 1'b0;
      allOffStrb_o  <= 1'b0;
    end else if (sys_reset) begin
      state         <= IDLE;
      cmd           <= '0;
      chan          <= '0;
      accept        <= 1'b0;
      d1            <= '0;
      armed         <= 1'b0;
      cnt           <= '0;
      note_o        <= '0;
      velocity_o    <= '0;
      channel_o     <= '0;
      noteOnStrb_o  <= 1'b0;
      noteOffStrb_o <= 1'b0;
      ccStrb_o      <= 1'b0;
      allOffStrb_o  <= 1'b0;
    end else begin
      state <= state_next;
      if (is_voice) begin
        cmd    <= midiByte_i[7:4];
        chan   <= midiByte_i[3:0];
        accept <= (OMNI != 0) || (midiByte_i[3:0] == CH);
      end else if (is_sys) begin
        cmd <= '0;
      end
      if (is_data && (state == DATA1)) d1 <= midiByte_i[6:0];
      // Any byte reloads the sense timer once Active Sensing has been seen.
      if (midiByteValid_i) begin
        if ((SENSE_TIMEOUT != 0) && (armed || (midiByte_i == 8'hFE))) begin
          armed <= 1'b1;
          cnt   <= LOAD;
        end
      end else if (armed) begin
        if (cnt == '0) armed <= 1'b0;
        else           cnt   <= cnt - 1'b1;
      end
      note_o        <= note_next;
      velocity_o    <= vel_next;
      channel_o     <= chan_next;
      noteOnStrb_o  <= on_next;
      noteOffStrb_o <= off_next;
      ccStrb_o      <= cc_next;
      allOffStrb_o  <= ao_cc || timer_fire;
    end
  end

  always_comb begin
    state_next = state;
    if (is_voice) begin
      state_next = DATA1;
    end else if (is_sys) begin
      state_next = SKIP;
    end else if (is_data) begin
      case (state)
        DATA1:   state_next = ((cmd == 4'hC) || (cmd == 4'hD)) ? DATA1 : DATA2;
        DATA2:   state_next = DATA1;
        default: state_next = state;
      endcase
    end
  end

  always_comb begin
    on_next   = 1'b0;
    off_next  = 1'b0;
    cc_next   = 1'b0;
    ao_cc     = 1'b0;
    note_next = note_o;
    vel_next  = velocity_o;
    chan_next = channel_o;
    if (complete && accept) begin
      case (cmd)
        4'h9: begin
          if ((midiByte_i[6:0] != 7'd0) || (VEL0_IS_OFF == 0)) on_next = 1'b1;
          else                                                  off_next = 1'b1;
        end
        4'h8: off_next = 1'b1;
        4'hB: begin
          cc_next = 1'b1;
          ao_cc   = (d1 == 7'd120) || (d1 == 7'd123);
        end
        default: ;
      endcase
      if (on_next || off_next || cc_next) begin
        note_next = to_payload(d1);
        vel_next  = to_payload(midiByte_i[6:0]);
        chan_next = chan;
      end
    end
  end

endmodule

// File: doc/midi_parser.md
Name: midi_parser

Overview:
- Parametrised successor to the single-channel note parser.
- Consumes a byte stream from the MIDI UART receiver and tracks running status, real-time bytes and system messages.
- Decodes Note On/Off and Control Change for one channel, or all channels in omni mode.
- Emits registered one-cycle strobes with note/controller number, velocity/value and channel, plus an all-notes-off strobe for the voice allocator.

Parameters:
- MIDI_CHANNEL, 0: channel (0-15) accepted when OMNI=0.
- OMNI, 0: 1 = accept all 16 channels; MIDI_CHANNEL is ignored.
- VEL0_IS_OFF, 1: 1 = Note On with velocity 0 is reported as Note Off.
- SENSE_TIMEOUT, 300000: clock cycles of byte silence after Active Sensing before allOffStrb_o fires. 0 disables the timeout.

Ports:
- clk_i  in  1  system clock.
- nrst_i  in  1  reset.
- midiByteValid_i  in  1  one-cycle qualifier for midiByte_i.
- midiByte_i  in  8  received MIDI byte.
- note_o  out  `MIDI_PAYLOAD_BITS  note number, or controller number on a CC strobe.
- velocity_o  out  `MIDI_PAYLOAD_BITS  velocity, or controller value on a CC strobe.
- channel_o  out  4  channel of the last reported message.
- noteOnStrb_o  out  1  one-cycle Note On event.
- noteOffStrb_o  out  1  one-cycle Note Off event.
- ccStrb_o  out  1  one-cycle Control Change event.
- allOffStrb_o  out  1  one-cycle all-notes-off request.

Behaviour:
- Interface: one clock, clk_i. nrst_i is an asynchronous, active-low reset.
- Reset values: all strobes 0, note_o/velocity_o/channel_o 0, state IDLE, running status cleared, sense timer disarmed.
- Byte classes:
  - status: bit7=1.
  - real-time: 0xF8-0xFF.
  - system common: 0xF0-0xF7.
  - data: bit7=0.
- Real-time bytes never change parser state or running status.
  - 0xFE arms the sense timer.
  - 0xFF (System Reset) behaves as a synchronous return to the reset state, without a strobe.
- Sense timer:
  - Reloads on every valid byte while armed.
  - On expiry it issues allOffStrb_o once and disarms.
- States: IDLE, DATA1, DATA2, SKIP.
- Channel voice status 0x80-0xEF, in any state:
  - latch cmd=byte[7:4] and chan=byte[3:0];
  - set accept = OMNI or (chan == MIDI_CHANNEL);
  - go to DATA1.
  - A partial message in progress is discarded.
- System common 0xF0-0xF7: clear running status and go to SKIP. SysEx data is dropped.
- Data byte in IDLE or SKIP: ignored.
- Data byte in DATA1:
  - latch d1.
  - cmd 0xC or 0xD (one-byte messages): message complete, stay in DATA1 (running status).
  - otherwise: go to DATA2.
- Data byte in DATA2: latch d2, message complete, return to DATA1 (running status).
- Completion with accept=1, cmd 0x9:
  - d2 != 0: noteOnStrb_o.
  - d2 == 0 and VEL0_IS_OFF=1: noteOffStrb_o.
  - d2 == 0 and VEL0_IS_OFF=0: noteOnStrb_o.
- Completion with accept=1, cmd 0x8: noteOffStrb_o.
- Completion with accept=1, cmd 0xB: ccStrb_o.
  - If d1 is 120 or 123, allOffStrb_o is also asserted in the same cycle.
- Completion with accept=1, cmd 0xA, 0xC, 0xD or 0xE: parsed for framing only, no strobe.
- Completion with accept=0: no strobe and no output change.
- Latency:
  - Strobes are registered and assert exactly 1 cycle after the completing byte's valid cycle, for 1 cycle.
  - note_o, velocity_o and channel_o update in that same cycle and hold until the next strobe.
- Width rule: data bytes supply bits [6:0]. They are zero-extended if `MIDI_PAYLOAD_BITS > 7, otherwise truncated to the low bits.
- At most one of noteOn/noteOff/cc strobes is active per cycle. allOffStrb_o may coincide with ccStrb_o.
- Timer expiry coinciding with a byte: the byte wins, the timer reloads and no allOff is issued.
- Reset asserted mid-message: all state, including running status, is cleared immediately. The following data bytes are ignored until a new status byte arrives.

Test Plan:
- 0x90,0x3C,0x64 on ch0, MIDI_CHANNEL=0 -> noteOnStrb_o 1 cycle after the third byte; note_o=60, velocity_o=100, channel_o=0.
- Running status: 0x90,0x3C,0x64,0x40,0x00 -> noteOn(60,100), then noteOffStrb_o with note_o=64, velocity_o=0. With VEL0_IS_OFF=0 -> noteOn(64,0) instead.
- 0x90,0x3C,0xF8,0x64 (clock byte interleaved) -> single noteOn(60,100); 0xF8 has no effect.
- 0x91,0x3C,0x64 with OMNI=0, MIDI_CHANNEL=0 -> no strobes. Same stimulus with OMNI=1 -> noteOn with channel_o=1.
- 0xC0,0x05,0x06 then 0x80,0x3C,0x00 -> no strobes for program change, then noteOff(60). 0x90,0x3C,0xF0,0x64 -> no strobe; data dropped in SKIP.
- 0xB0,0x7B,0x00 -> ccStrb_o and allOffStrb_o together. 0xFE then silence with SENSE_TIMEOUT=100 -> allOffStrb_o at cycle 100 after 0xFE, exactly once. Reset mid-message -> next bare data bytes produce no strobes.
